// File: rtl/rmw_long_latency_tbl_if.sv
// Table request/response bundle for rmw_long_latency_tbl, plus shared widths.
// master = cache side, slave = table side.
package rmw_long_latency_pkg;
  localparam int ID_W   = 4;
  localparam int WORD_W = 32;
  localparam int TAG_W  = 4;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef struct packed {
    logic vld;
    id_t  id;
    tag_t tag;
  } rd_req_t;
endpackage

interface rmw_long_latency_tbl_if;
  import rmw_long_latency_pkg::*;

  logic  tbl_rd_r;
  id_t   tbl_rd_id_r;
  tag_t  tbl_rd_itag_r;
  logic  tbl_wr_r;
  id_t   tbl_wr_id_r;
  word_t tbl_wr_word_r;
  logic  tbl_rd_word_vld_r;
  word_t tbl_rd_word_r;
  tag_t  tbl_rd_ctag_r;
  logic  tbl_busy_r;

  modport master (
    output tbl_rd_r, tbl_rd_id_r, tbl_rd_itag_r,
    output tbl_wr_r, tbl_wr_id_r, tbl_wr_word_r,
    input  tbl_rd_word_vld_r, tbl_rd_word_r,
    input  tbl_rd_ctag_r, tbl_busy_r
  );

  modport slave (
    input  tbl_rd_r, tbl_rd_id_r, tbl_rd_itag_r,
    input  tbl_wr_r, tbl_wr_id_r, tbl_wr_word_r,
    output tbl_rd_word_vld_r, tbl_rd_word_r,
    output tbl_rd_ctag_r, tbl_busy_r
  );
endinterface

// File: rtl/rmw_long_latency_tbl.sv
// Long-latency backing word table: reads answer LATENCY cycles later.
// Define RMW_LONG_LATENCY_TBL_WR_FWD_EN to forward a same-cycle write.
module rmw_long_latency_tbl
  import rmw_long_latency_pkg::*;
#(
  parameter int LATENCY = 8
) (
  input logic clk,
  input logic rst,
  rmw_long_latency_tbl_if.slave tbl
);

  localparam int DEPTH = 2**ID_W;

  word_t   mem_q [DEPTH];
  rd_req_t rd_in;
  rd_req_t last;
  logic    pipe_busy;
  word_t   rd_word_d;
  logic    vld_q;
  word_t   word_q;
  tag_t    ctag_q;
  logic    busy_q;

  // pack the incoming read request
  always_comb begin
    rd_in.vld = tbl.tbl_rd_r;
    rd_in.id  = tbl.tbl_rd_id_r;
    rd_in.tag = tbl.tbl_rd_itag_r;
  end

  // output register is the final stage; the
  // shift register holds the LATENCY-1 before it
  if (LATENCY == 1) begin : g_nopipe
    assign last      = rd_in;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    rd_req_t pipe_q [LATENCY-1];

    // shift read requests toward the output stage
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY-1; i++)
          pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= rd_in;
        for (int i = 1; i < LATENCY-1; i++)
          pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign last = pipe_q[LATENCY-2];

    // any read still travelling the pipe
    always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < LATENCY-1; i++)
        pipe_busy = pipe_busy | pipe_q[i].vld;
    end
  end

  // table storage, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (tbl.tbl_wr_r) begin
      mem_q[tbl.tbl_wr_id_r] <= tbl.tbl_wr_word_r;
    end
  end

  // response word, optionally bypassing a same-cycle write
  always_comb begin
    rd_word_d = mem_q[last.id];
`ifdef RMW_LONG_LATENCY_TBL_WR_FWD_EN
    if (tbl.tbl_wr_r && (tbl.tbl_wr_id_r == last.id))
      rd_word_d = tbl.tbl_wr_word_r;
`else
    rd_word_d = mem_q[last.id];
`endif
  end

  // registered response and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      word_q <= '0;
      ctag_q <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= last.vld;
      busy_q <= tbl.tbl_rd_r | pipe_busy;
      if (last.vld) begin
        word_q <= rd_word_d;
        ctag_q <= last.tag;
      end
    end
  end

  assign tbl.tbl_rd_word_vld_r = vld_q;
  assign tbl.tbl_rd_word_r     = word_q;
  assign tbl.tbl_rd_ctag_r     = ctag_q;
  assign tbl.tbl_busy_r        = busy_q;

endmodule
